record_mode: RTL and testbench

Captures a performance from the key-control stream (4-bit note code plus on flag) into an on-chip event buffer as (note, on, duration) segments. It then replays that buffer as the same note/note_on stream that the buzzer and LED controllers consume. It is the writer counterpart of the song-playback path: where playback reads a fixed song table and drives notes, this block writes a song table from live key input and can read it back. It sits between the key-control module and the buzzer/LED note mux in the top level.

---
 rtl/record_mode.sv | 178 +++++++++++++++++
 tb/tb_record_mode.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/record_mode.sv
// Live key-stream recorder and replayer: captures (note, on, duration) segments
// into an on-chip buffer and plays them back as a gap-free note/note_on stream.
module record_mode #(
  parameter int TICK_CYCLES = 1_000_000,
  parameter int DEPTH       = 64,
  parameter int DUR_W       = 8,
  parameter int AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rec_start,
  input  logic          play_start,
  input  logic          stop,
  input  logic          loop,
  input  logic [3:0]    key_in,
  input  logic          key_in_on,
  output logic [3:0]    note,
  output logic          note_on,
  output logic          recording,
  output logic          playing,
  output logic          full,
  output logic [AW:0]   count
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int EW = 5 + DUR_W;
  localparam int CW = AW + 1;
  localparam logic [PW-1:0]    PMAX    = PW'(TICK_CYCLES - 1);
  localparam logic [DUR_W-1:0] MAXD    = '1;
  localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, RECORD, PLAY} state_t;

  state_t state, state_n;

  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    ram_q;
  logic [PW-1:0]    presc;
  logic [DUR_W-1:0] dur;
  logic [3:0]       seg_note;
  logic             seg_on;
  logic [AW-1:0]    rd_addr, rd_addr_n, last_addr;
  logic             lead, seg_live, cur_last;

  logic [3:0] cur_note;
  logic       cur_on;
  logic       wrap, change, sat;
  logic       rec_begin, rec_write;
  logic       play_begin, play_active, play_load, seg_end, play_done;

  assign recording = (state == RECORD);
  assign playing   = (state == PLAY);
  assign full      = (count == DEPTH_C);

  always_comb begin
    cur_note  = key_in_on ? key_in : 4'd0;
    cur_on    = key_in_on;
    wrap      = (presc == PMAX);
    last_addr = AW'(count - 1'b1);
    change    = ({cur_note, cur_on} != {seg_note, seg_on});
    sat       = !change && wrap && (dur == MAXD);

    rec_begin  = !stop && rec_start;
    play_begin = !stop && !rec_start && play_start && (count != '0) && (state != RECORD);
    rec_write  = (state == RECORD) && !rec_begin && (stop || change || sat) && (count < DEPTH_C);

    // In PLAY, dur counts down the ticks left in the segment on the output register.
    play_active = (state == PLAY) && !stop && !rec_start && !play_start;
    seg_end     = seg_live && wrap && (dur == DUR_ONE);
    play_load   = play_active && ((!lead && !seg_live) || (seg_end && (!cur_last || loop)));
    play_done   = play_active && seg_end && cur_last && !loop;

    // RAM is addressed with the next read pointer so ram_q always holds the entry
    // rd_addr points at, which keeps back-to-back segments gap-free.
    rd_addr_n = rd_addr;
    if (play_begin)
      rd_addr_n = '0;
    else if (play_load)
      rd_addr_n = (rd_addr == last_addr) ? '0 : rd_addr + 1'b1;

    state_n = state;
    if (stop)
      state_n = IDLE;
    else if (rec_start)
      state_n = RECORD;
    else begin
      case (state)
        IDLE:    if (play_begin) state_n = PLAY;
        RECORD:  if (rec_write && (count == DEPTH_C - 1'b1)) state_n = IDLE;
        PLAY:    if (play_done) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rec_write)
      mem[count[AW-1:0]] <= {seg_note, seg_on, dur};
    ram_q <= mem[rd_addr_n];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      presc    <= '0;
      dur      <= '0;
      seg_note <= '0;
      seg_on   <= 1'b0;
      rd_addr  <= '0;
      lead     <= 1'b0;
      seg_live <= 1'b0;
      cur_last <= 1'b0;
      note     <= '0;
      note_on  <= 1'b0;
    end else begin
      state   <= state_n;
      rd_addr <= rd_addr_n;

      if (rec_begin || rec_write || play_begin || play_load || wrap)
        presc <= '0;
      else
        presc <= presc + 1'b1;

      if (rec_begin) begin
        count    <= '0;
        seg_note <= cur_note;
        seg_on   <= cur_on;
      end else if (rec_write) begin
        count    <= count + 1'b1;
        seg_note <= cur_note;
        seg_on   <= cur_on;
      end

      if (rec_begin || rec_write)
        dur <= DUR_ONE;
      else if (play_load)
        dur <= ram_q[DUR_W-1:0];
      else if ((state == RECORD) && wrap)
        dur <= dur + 1'b1;
      else if ((state == PLAY) && seg_live && wrap)
        dur <= dur - 1'b1;

      if (play_begin) begin
        lead     <= 1'b1;
        seg_live <= 1'b0;
      end else begin
        lead     <= 1'b0;
        seg_live <= (state_n == PLAY) && (seg_live || play_load);
      end

      if (play_load)
        cur_last <= (rd_addr == last_addr);

      case (state_n)
        RECORD: begin
          note    <= cur_note;
          note_on <= cur_on;
        end
        PLAY: begin
          if (play_load) begin
            note    <= ram_q[EW-1 -: 4];
            note_on <= ram_q[DUR_W];
          end else if (play_begin) begin
            note    <= '0;
            note_on <= 1'b0;
          end
        end
        default: begin
          note    <= '0;
          note_on <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_record_mode.sv
// Directed bench for record_mode with TICK_CYCLES=4, DEPTH=4, DUR_W=3.
module tb_record_mode;
  localparam int TICK  = 4;
  localparam int DEPTH = 4;
  localparam int DUR_W = 3;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst, rec_start, play_start, stop, loop, key_in_on;
  logic [3:0]    key_in;
  logic [3:0]    note;
  logic          note_on, recording, playing, full;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rs, ps, sp, lp;
    logic [3:0] key;
    logic       kon;
    int         en, eon, erec, eplay, efull, ecnt;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  record_mode #(.TICK_CYCLES(TICK), .DEPTH(DEPTH), .DUR_W(DUR_W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .rec_start(rec_start), .play_start(play_start),
    .stop(stop), .loop(loop), .key_in(key_in), .key_in_on(key_in_on),
    .note(note), .note_on(note_on), .recording(recording), .playing(playing),
    .full(full), .count(count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rs, input logic ps, input logic sp, input logic lp,
                       input logic [3:0] k, input logic kon);
    rec_start  = rs;
    play_start = ps;
    stop       = sp;
    loop       = lp;
    key_in     = k;
    key_in_on  = kon;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int en, input int eon, input int erec,
                         input int eplay, input int efull, input int ecnt);
    chk({tag, " note"}, int'(note), en);
    chk({tag, " note_on"}, int'(note_on), eon);
    chk({tag, " recording"}, int'(recording), erec);
    chk({tag, " playing"}, int'(playing), eplay);
    chk({tag, " full"}, int'(full), efull);
    chk({tag, " count"}, int'(count), ecnt);
  endtask

  task automatic add(input logic rs, input logic ps, input logic sp, input logic [3:0] k,
                     input logic kon, input int en, input int eon, input int erec,
                     input int eplay, input int ecnt);
    vec_t v;
    v.rs = rs; v.ps = ps; v.sp = sp; v.lp = 1'b0; v.key = k; v.kon = kon;
    v.en = en; v.eon = eon; v.erec = erec; v.eplay = eplay; v.efull = 0; v.ecnt = ecnt;
    vecs.push_back(v);
  endtask

  initial begin
    int good;
    int exp_on;

    // Basic record: off 1 cycle, key 3 on 8 cycles, off 4 cycles, stop.
    add(1, 0, 0, 4'd0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 0, 4'd3, 1, 3, 1, 1, 0, 1);
    add(0, 0, 0, 4'd0, 0, 0, 0, 1, 0, 2);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 4'd0, 0, 0, 0, 1, 0, 2);
    add(0, 0, 1, 4'd0, 0, 0, 0, 0, 0, 3);
    // Playback of {0,0,1},{3,1,2},{0,0,1}: two cycles of start latency.
    add(0, 1, 0, 4'd0, 0, 0, 0, 0, 1, 3);
    add(0, 0, 0, 4'd0, 0, 0, 0, 0, 1, 3);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 4'd0, 0, 0, 0, 0, 1, 3);
    for (int i = 0; i < 8; i++) add(0, 0, 0, 4'd0, 0, 3, 1, 0, 1, 3);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 4'd0, 0, 0, 0, 0, 1, 3);
    add(0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 3);

    rst = 1'b1;
    drive(0, 0, 0, 0, 4'd0, 0);
    step();
    step();
    chk_out("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // play_start with an empty buffer is ignored.
    drive(0, 1, 0, 0, 4'd0, 0);
    step();
    drive(0, 0, 0, 0, 4'd0, 0);
    chk_out("empty play", 0, 0, 0, 0, 0, 0);
    step();
    chk("empty play later playing", int'(playing), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rs, vecs[i].ps, vecs[i].sp, vecs[i].lp, vecs[i].key, vecs[i].kon);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].en, vecs[i].eon, vecs[i].erec,
              vecs[i].eplay, vecs[i].efull, vecs[i].ecnt);
    end
    drive(0, 0, 0, 0, 4'd0, 0);

    // Saturation: key 5 held 40 cycles from the rec_start edge -> {5,1,7},{5,1,3}.
    drive(1, 0, 0, 0, 4'd5, 1);
    step();
    chk_out("sat start", 5, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 4'd5, 1);
    for (int i = 1; i < 40; i++) begin
      step();
      if (i == 27) chk("sat count before chunk", int'(count), 0);
      if (i == 28) chk("sat count after chunk", int'(count), 1);
    end
    drive(0, 0, 1, 0, 4'd5, 1);
    step();
    chk_out("sat stop", 0, 0, 0, 0, 0, 2);
    drive(0, 1, 0, 0, 4'd0, 0);
    step();
    drive(0, 0, 0, 0, 4'd0, 0);
    step();
    chk("sat lead note_on", int'(note_on), 0);
    good = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (note == 4'd5 && note_on && playing) good++;
    end
    chk("sat hold cycles", good, 40);
    step();
    chk("sat end note_on", int'(note_on), 0);
    chk("sat end playing", int'(playing), 0);

    // Full: four changes fill the buffer, fifth is not stored.
    drive(1, 0, 0, 0, 4'd0, 0);
    step();
    chk("full start count", int'(count), 0);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 0, 4'd9, logic'(i % 2));
      step();
      chk($sformatf("full count %0d", i), int'(count), i);
    end
    chk("full flag", int'(full), 1);
    chk("full recording", int'(recording), 0);
    drive(0, 0, 0, 0, 4'd9, 1);
    step();
    chk_out("full ignored", 0, 0, 0, 0, 1, 4);

    // Loop: record {7,1,1},{0,0,1}, then replay with loop held.
    drive(1, 0, 0, 0, 4'd7, 1);
    step();
    drive(0, 0, 0, 0, 4'd7, 1);
    for (int i = 0; i < 3; i++) step();
    drive(0, 0, 0, 0, 4'd0, 0);
    step();
    chk("loop rec count1", int'(count), 1);
    for (int i = 0; i < 3; i++) step();
    drive(0, 0, 1, 0, 4'd0, 0);
    step();
    chk("loop rec count2", int'(count), 2);
    drive(0, 1, 0, 1, 4'd0, 0);
    step();
    drive(0, 0, 0, 1, 4'd0, 0);
    step();
    good = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      exp_on = ((i / 4) % 2 == 0) ? 1 : 0;
      if (int'(note_on) == exp_on && int'(note) == (exp_on != 0 ? 7 : 0) && playing) good++;
    end
    chk("loop pattern cycles", good, 24);
    drive(0, 0, 1, 1, 4'd0, 0);
    step();
    chk("loop stop note_on", int'(note_on), 0);
    chk("loop stop playing", int'(playing), 0);
    drive(0, 0, 0, 0, 4'd0, 0);

    // stop beats rec_start while playing.
    drive(0, 1, 0, 0, 4'd0, 0);
    step();
    drive(0, 0, 0, 0, 4'd0, 0);
    step();
    chk("prio playing", int'(playing), 1);
    drive(1, 0, 1, 0, 4'd0, 0);
    step();
    chk_out("prio stop+rec", 0, 0, 0, 0, 0, 2);

    // rec_start aborts playback; rst mid-record clears everything.
    drive(0, 1, 0, 0, 4'd0, 0);
    step();
    drive(1, 0, 0, 0, 4'd0, 0);
    step();
    chk_out("abort play", 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 4'd2, 1);
    step();
    chk_out("rec before rst", 2, 1, 1, 0, 0, 1);
    rst = 1'b1;
    step();
    chk_out("rst mid record", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
